// File: rtl/state_main_seq.sv
// Main train/inference sequencer: walks N_STAGE compute stages forward, then backward,
// once per sample of a batch, then runs one update, with a start/done handshake per phase.
`ifndef MODE_LEN
`define MODE_LEN 2
`endif
`ifndef TRAIN
`define TRAIN 2'd1
`endif

module state_main_seq #(
  parameter int N_STAGE = 3,
  parameter int IDX_W   = 2,
  parameter int BATCH_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 abort,
  input  logic [`MODE_LEN-1:0] mode,
  input  logic [BATCH_W-1:0]   batch_size,
  input  logic                 stage_done,
  input  logic                 upd_done,
  output logic [2:0]           q,
  output logic [IDX_W-1:0]     stage_idx,
  output logic                 bwd,
  output logic                 stage_start,
  output logic                 upd_start,
  output logic [BATCH_W-1:0]   sample_cnt,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    BWD    = 3'd2,
    UPDATE = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGE - 1);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [BATCH_W-1:0]     cnt, cnt_n;
  logic                   issued, issued_n;
  logic                   seen, seen_n;
  logic [`MODE_LEN-1:0]   mode_r, mode_n;
  logic                   done_r, done_n;

  logic                   active;
  logic                   phase_done;
  logic                   start;
  logic                   advance;
  logic                   train;
  logic [BATCH_W:0]       cnt_inc;
  logic [BATCH_W:0]       eff_batch;

  assign active     = (state == FWD) || (state == BWD) || (state == UPDATE);
  assign phase_done = (state == UPDATE) ? upd_done : stage_done;
  assign start      = active && !issued && run && !abort;
  assign advance    = active && run && issued && (seen || phase_done);
  assign train      = (mode_r == `TRAIN);
  assign cnt_inc    = {1'b0, cnt} + (BATCH_W + 1)'(1);
  assign eff_batch  = (batch_size == '0) ? (BATCH_W + 1)'(1) : {1'b0, batch_size};

  // NOTE: every next-state variable gets its hold value first, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    issued_n = issued;
    seen_n   = seen;
    mode_n   = mode_r;
    done_n   = 1'b0;

    if (abort) begin
      state_n  = IDLE;
      idx_n    = '0;
      cnt_n    = '0;
      issued_n = 1'b0;
      seen_n   = 1'b0;
    end else begin
      if (start) issued_n = 1'b1;
      // A completion is remembered even while paused, so it is not lost.
      if (active && issued && phase_done) seen_n = 1'b1;

      unique case (state)
        IDLE: begin
          if (run) begin
            mode_n  = mode;
            state_n = FWD;
            idx_n   = '0;
          end
        end
        FWD: begin
          if (advance) begin
            if (idx < LAST_IDX) idx_n = idx + IDX_W'(1);
            else if (train)     state_n = BWD;
            else                state_n = FIN;
          end
        end
        BWD: begin
          if (advance) begin
            if (idx != '0) begin
              idx_n = idx - IDX_W'(1);
            end else if (cnt_inc >= eff_batch) begin
              state_n = UPDATE;
              cnt_n   = '0;
            end else begin
              state_n = FWD;
              idx_n   = '0;
              cnt_n   = cnt_inc[BATCH_W-1:0];
            end
          end
        end
        UPDATE: begin
          if (advance) state_n = FIN;
        end
        FIN: begin
          if (run && train) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase

      if (advance) begin
        issued_n = 1'b0;
        seen_n   = 1'b0;
      end
      if (state_n == FIN && state != FIN) done_n = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      issued <= 1'b0;
      seen   <= 1'b0;
      mode_r <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      issued <= issued_n;
      seen   <= seen_n;
      mode_r <= mode_n;
      done_r <= done_n;
    end
  end

  assign q           = state;
  assign stage_idx   = idx;
  assign bwd         = (state == BWD);
  assign stage_start = start && (state != UPDATE);
  assign upd_start   = start && (state == UPDATE);
  assign sample_cnt  = cnt;
  assign busy        = active;
  assign done        = done_r;

endmodule

// File: tb/tb_state_main_seq.sv
// Scoreboard bench for state_main_seq: expected start/done events are queued by the
// stimulus and popped by a monitor whenever the sequencer emits one.
`ifndef MODE_LEN
`define MODE_LEN 2
`endif
`ifndef TRAIN
`define TRAIN 2'd1
`endif

module tb_state_main_seq;

  localparam int N_STAGE = 3;
  localparam int IDX_W   = 2;
  localparam int BATCH_W = 4;

  localparam logic [1:0] EV_STAGE = 2'd0;
  localparam logic [1:0] EV_UPD   = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;

  localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_BWD = 3'd2, S_UPD = 3'd3, S_FIN = 3'd4;

  typedef struct packed {
    logic [1:0]         kind;
    logic [2:0]         q;
    logic [IDX_W-1:0]   idx;
    logic [BATCH_W-1:0] cnt;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 run;
  logic                 abort;
  logic [`MODE_LEN-1:0] mode;
  logic [BATCH_W-1:0]   batch_size;
  logic                 stage_done;
  logic                 upd_done;
  logic [2:0]           q;
  logic [IDX_W-1:0]     stage_idx;
  logic                 bwd;
  logic                 stage_start;
  logic                 upd_start;
  logic [BATCH_W-1:0]   sample_cnt;
  logic                 busy;
  logic                 done;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t sb[$];
  bit  auto_resp = 1'b0;

  state_main_seq #(.N_STAGE(N_STAGE), .IDX_W(IDX_W), .BATCH_W(BATCH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .abort      (abort),
    .mode       (mode),
    .batch_size (batch_size),
    .stage_done (stage_done),
    .upd_done   (upd_done),
    .q          (q),
    .stage_idx  (stage_idx),
    .bwd        (bwd),
    .stage_start(stage_start),
    .upd_start  (upd_start),
    .sample_cnt (sample_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [2:0] st, input int idx, input int cnt);
    ev_t e;
    e.kind = kind;
    e.q    = st;
    e.idx  = (kind == EV_DONE) ? '0 : IDX_W'(idx);
    e.cnt  = BATCH_W'(cnt);
    sb.push_back(e);
  endtask

  // One forward pass and, when train is set, the matching backward pass.
  task automatic push_pass(input int cnt, input bit with_bwd);
    for (int i = 0; i < N_STAGE; i++) push(EV_STAGE, S_FWD, i, cnt);
    if (with_bwd)
      for (int i = N_STAGE - 1; i >= 0; i--) push(EV_STAGE, S_BWD, i, cnt);
  endtask

  task automatic pop_cmp(input logic [1:0] kind);
    ev_t act, exp;
    act.kind = kind;
    act.q    = q;
    act.idx  = (kind == EV_DONE) ? '0 : stage_idx;
    act.cnt  = sample_cnt;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got 0x%0h expected none at %0t", act, $time);
    end else begin
      exp = sb.pop_front();
      check("event", 32'(act), 32'(exp));
    end
  endtask

  // Monitor: every start or done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stage_start) pop_cmp(EV_STAGE);
      if (upd_start)   pop_cmp(EV_UPD);
      if (done)        pop_cmp(EV_DONE);
    end
  end

  // Auto responder: completion pulse in the cycle after each observed start.
  always begin
    bit ps, pu;
    @(negedge clk);
    ps = auto_resp && stage_start;
    pu = auto_resp && upd_start;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      stage_done = ps;
      upd_done   = pu;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic idle_out(input string name);
    check({name, "_q"}, 32'(q), 32'(S_IDLE));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; abort = 1'b0; mode = '0; batch_size = '0;
    stage_done = 1'b0; upd_done = 1'b0;
    #2;
    check("reset_outputs", {q, stage_idx, bwd, stage_start, upd_start, sample_cnt, busy, done}, '0);
    tick();
    tick();
    rst_n = 1'b1;

    // Train, batch 2, done one cycle after each start; mode toggled mid-run.
    mode = `TRAIN; batch_size = 4'd2; auto_resp = 1'b1;
    push_pass(0, 1'b1);
    push_pass(1, 1'b1);
    push(EV_UPD, S_UPD, 0, 0);
    push(EV_DONE, S_FIN, 0, 0);
    run = 1'b1;
    repeat (5) tick();
    mode = 2'd0;
    wait_done("train", 200);
    tick();
    run = 1'b0;
    #1;
    idle_out("train_end");
    check("train_done_single", 32'(done), 32'd0);

    // Inference: three forward stages then FIN, which holds until abort.
    mode = 2'd0; batch_size = 4'd2;
    push_pass(0, 1'b0);
    push(EV_DONE, S_FIN, 0, 0);
    tick();
    run = 1'b1;
    wait_done("infer", 200);
    repeat (20) tick();
    check("infer_fin_hold", 32'(q), 32'(S_FIN));
    check("infer_done_low", 32'(done), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0; run = 1'b0;
    idle_out("infer_abort");

    // Pause: done arrives while run is low, progress resumes only when run returns.
    auto_resp = 1'b0; stage_done = 1'b0; upd_done = 1'b0;
    mode = `TRAIN; batch_size = 4'd1;
    push(EV_STAGE, S_FWD, 0, 0);
    push(EV_STAGE, S_FWD, 1, 0);
    run = 1'b1;
    tick();
    tick();
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    tick();
    run = 1'b0;
    tick();
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    repeat (3) tick();
    check("pause_q", 32'(q), 32'(S_FWD));
    check("pause_idx", 32'(stage_idx), 32'd1);
    check("pause_no_start", 32'(stage_start), 32'd0);
    push(EV_STAGE, S_FWD, 2, 0);
    run = 1'b1;
    tick();
    check("resume_q", 32'(q), 32'(S_FWD));
    check("resume_idx", 32'(stage_idx), 32'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; run = 1'b0;
    idle_out("pause_abort");

    // Spurious done in IDLE, then a repeated done within one phase.
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("spurious_idle_q", 32'(q), 32'(S_IDLE));
    push(EV_STAGE, S_FWD, 0, 0);
    push(EV_STAGE, S_FWD, 1, 0);
    run = 1'b1;
    tick();
    tick();
    stage_done = 1'b1;
    tick();
    tick();
    stage_done = 1'b0;
    repeat (2) tick();
    check("double_done_q", 32'(q), 32'(S_FWD));
    check("double_done_idx", 32'(stage_idx), 32'd1);
    push(EV_STAGE, S_FWD, 2, 0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("double_done_next_idx", 32'(stage_idx), 32'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; run = 1'b0;
    idle_out("double_abort");

    // batch_size 0 acts as batch 1: one pass then UPDATE.
    mode = `TRAIN; batch_size = 4'd0; auto_resp = 1'b1;
    push_pass(0, 1'b1);
    push(EV_UPD, S_UPD, 0, 0);
    push(EV_DONE, S_FIN, 0, 0);
    run = 1'b1;
    wait_done("batch0", 200);
    tick();
    run = 1'b0;
    #1;
    idle_out("batch0_end");

    // Asynchronous reset in the middle of BWD.
    mode = `TRAIN; batch_size = 4'd2;
    for (int i = 0; i < N_STAGE; i++) push(EV_STAGE, S_FWD, i, 0);
    push(EV_STAGE, S_BWD, N_STAGE - 1, 0);
    tick();
    run = 1'b1;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (bwd) got = 1'b1;
      end
      check("reach_bwd", 32'(got), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {q, stage_idx, bwd, stage_start, upd_start, sample_cnt, busy, done}, '0);
    check("async_reset_sb_empty", 32'(sb.size()), 32'd0);
    auto_resp = 1'b0; stage_done = 1'b0; upd_done = 1'b0; run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_q", 32'(q), 32'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/state_main_seq.md
Name: state_main_seq

Overview:
- Parametrised main sequencer for the train/inference datapath; successor to the fixed-step main state machine.
- Walks a configurable number of compute stages: forward, then backward in reverse order, repeated per sample for a runtime batch size, then one update.
- Each stage and the update phase runs under a start/done handshake with the stage engines.
- Sits above the per-stage state machines and drives their start pulses and direction.

Parameters:
N_STAGE, 3, number of compute stages (>=1)
IDX_W, 2, width of stage index; 2**IDX_W >= N_STAGE
BATCH_W, 4, width of batch size and sample counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level enable; low = pause
abort  in  1  synchronous abort to IDLE, highest priority after reset
mode  in  `MODE_LEN  `TRAIN selects training; any other value = inference
batch_size  in  BATCH_W  samples per update; 0 treated as 1
stage_done  in  1  one-cycle completion pulse from the active stage
upd_done  in  1  one-cycle completion pulse from the update engine
q  out  3  state: IDLE=0, FWD=1, BWD=2, UPDATE=3, FIN=4
stage_idx  out  IDX_W  active stage index
bwd  out  1  high in BWD
stage_start  out  1  one-cycle start to stage stage_idx
upd_start  out  1  one-cycle start to update engine
sample_cnt  out  BATCH_W  samples completed in current batch
busy  out  1  q not IDLE and not FIN
done  out  1  one-cycle pulse on entry to FIN

Behaviour:
- Reset (async): q=IDLE, stage_idx=0, sample_cnt=0, issued=0, seen=0, mode_r=0. All outputs 0.
- Sequencing:
  - IDLE: on run=1, latch mode into mode_r, go FWD with idx=0.
  - Mode changes after the IDLE->FWD edge are ignored until the next IDLE exit.
- Stage handshake (FWD/BWD/UPDATE):
  - stage_start (or upd_start in UPDATE) = phase active & !issued & run. This is combinational from registers and run.
  - issued sets on the cycle the start is asserted.
  - A done pulse while issued=1 sets a sticky seen flag, including while run=0. Done pulses while issued=0, or in IDLE/FIN, are ignored.
  - The phase advances on the first edge with run=1 and (seen or done). issued and seen clear on every phase/index change.
- FWD: idx<N_STAGE-1 -> idx+1. Last stage: train -> BWD with idx=N_STAGE-1; inference -> FIN.
- BWD: idx>0 -> idx-1. At idx=0, sample_cnt+1:
  - if the new count >= max(batch_size,1): go UPDATE, sample_cnt=0;
  - else go FWD with idx=0.
- UPDATE: advance to FIN after handshake.
- FIN:
  - done=1 for the single cycle q first equals FIN.
  - Train: FIN -> IDLE on next edge with run=1.
  - Inference: FIN holds until abort.
- abort=1: next edge q=IDLE, idx=0, sample_cnt=0, flags clear. No start is issued that cycle.
- batch_size is sampled at each BWD idx=0 completion. Reducing it below sample_cnt forces UPDATE at the next completion.
- run=0 freezes all state (except seen capture) and suppresses start pulses. No start is ever issued twice for the same phase/index.
- Minimum latency per stage phase: 2 cycles (start cycle, then done at the earliest next cycle).

Test Plan:
- N_STAGE=3, train, batch_size=2, run=1, done returned 1 cycle after each start -> q/idx sequence:
  - FWD0, FWD1, FWD2, BWD2, BWD1, BWD0, FWD0, FWD1, FWD2, BWD2, BWD1, BWD0, UPDATE, FIN, IDLE;
  - exactly 12 stage_start and 1 upd_start; done pulses once; sample_cnt reads 1 after the first BWD0.
- Inference, N_STAGE=3 -> FWD0..FWD2 then FIN with one done pulse; q stays 4 for 20 cycles; abort -> q=0 next cycle.
- Pause: in FWD1, drop run after start; stage_done arrives with run=0 -> q holds at FWD/1, no start. Raise run -> FWD2 next edge, one start.
- batch_size=0, train -> behaves as batch 1: single FWD/BWD pass, then UPDATE.
- Spurious stage_done in IDLE and a second stage_done in the same phase -> ignored; no skipped index.
- rst_n low mid-BWD -> all outputs 0 immediately, no clock needed; mode toggled mid-run -> sequence unchanged.
